// File: rtl/int_request_unit.sv
// Interrupt initiator: latches peripheral IRQ edges, masks and prioritises them and drives one
// of two level request lines to the CPU controller. Optional completion timeout: IRQ_TIMEOUT_EN.
module int_request_unit #(
  parameter int NUM_SRC        = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] i_irq,
  input  logic               i_recovery,
  input  logic               i_cfg_we,
  input  logic [1:0]         i_cfg_addr,
  input  logic [15:0]        i_cfg_wdata,
  output logic [15:0]        o_cfg_rdata,
  output logic               o_inta,
  output logic               o_intb,
  output logic [3:0]         o_int_id,
  output logic               o_busy
);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  state_t             state, state_next;
  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [NUM_SRC-1:0] pending, mask, route;
  logic [NUM_SRC-1:0] rise, cand, win_oh, grant_clr, w1c;
  logic [3:0]         win, id_next;
  logic               grant, route_bit, timeout_hit, timeout_flag;
  logic               inta_next, intb_next;
  logic [GW-1:0]      gap_cnt, gap_next;
  logic               unused_wdata;

  assign unused_wdata = ^i_cfg_wdata;

  // Two-stage synchroniser plus a third stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= i_irq;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign cand = pending & mask;

  always_comb begin
    win    = '0;
    win_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win       = 4'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign route_bit = |(route & win_oh);
  assign grant_clr = grant ? win_oh : '0;
  assign w1c       = (i_cfg_we && i_cfg_addr == 2'd2) ? i_cfg_wdata[NUM_SRC-1:0] : '0;

  // A new edge wins over a same-cycle grant clear or W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      route   <= '0;
    end else begin
      pending <= (pending & ~grant_clr & ~w1c) | rise;
      if (i_cfg_we && i_cfg_addr == 2'd0) mask  <= i_cfg_wdata[NUM_SRC-1:0];
      if (i_cfg_we && i_cfg_addr == 2'd1) route <= i_cfg_wdata[NUM_SRC-1:0];
    end
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          abort;

  assign timeout_hit = (state == ASSERT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign abort       = timeout_hit && !i_recovery;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (grant) tmo_cnt <= '0;
      else if (state == ASSERT) tmo_cnt <= tmo_cnt + TW'(1);
      if (abort) timeout_flag <= 1'b1;
      else if (i_cfg_we && i_cfg_addr == 2'd3 && i_cfg_wdata[14]) timeout_flag <= 1'b0;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      o_inta   <= 1'b0;
      o_intb   <= 1'b0;
      o_int_id <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_next;
      o_inta   <= inta_next;
      o_intb   <= intb_next;
      o_int_id <= id_next;
      gap_cnt  <= gap_next;
    end
  end

  // GAP leaves one cycle early so the next grant lands GAP_CYCLES+1 cycles after completion
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    inta_next  = o_inta;
    intb_next  = o_intb;
    id_next    = o_int_id;
    gap_next   = gap_cnt;
    case (state)
      IDLE: begin
        if (|cand) begin
          grant      = 1'b1;
          id_next    = win;
          inta_next  = !route_bit;
          intb_next  = route_bit;
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (i_recovery || timeout_hit) begin
          inta_next  = 1'b0;
          intb_next  = 1'b0;
          gap_next   = GW'(GAP_CYCLES);
          state_next = GAP;
        end
      end
      GAP: begin
        gap_next = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy = (state == ASSERT);

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_addr)
      2'd0:    o_cfg_rdata[NUM_SRC-1:0] = mask;
      2'd1:    o_cfg_rdata[NUM_SRC-1:0] = route;
      2'd2:    o_cfg_rdata[NUM_SRC-1:0] = pending;
      default: o_cfg_rdata = {o_busy, timeout_flag, 10'd0, o_int_id};
    endcase
  end
endmodule

// File: tb/tb_int_request_unit.sv
// Self-checking bench for int_request_unit: table of arbitration/routing vectors plus
// hand-written sequences for gap timing, unmask, merge, reset and timeout (IRQ_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_int_request_unit;
  localparam int NUM_SRC = 8;
  localparam int GAP     = 2;
  localparam int TMO     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] i_irq;
  logic               i_recovery;
  logic               i_cfg_we;
  logic [1:0]         i_cfg_addr;
  logic [15:0]        i_cfg_wdata;
  logic [15:0]        o_cfg_rdata;
  logic               o_inta, o_intb, o_busy;
  logic [3:0]         o_int_id;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] route;
    logic [7:0] irq;
    logic       exp_a;
    logic       exp_b;
    logic [3:0] exp_id;
    logic       exp_busy;
    logic [7:0] exp_pend;
  } vec_t;

  vec_t vecs[7];

  int_request_unit #(.NUM_SRC(NUM_SRC), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .i_irq(i_irq), .i_recovery(i_recovery),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
    .o_cfg_rdata(o_cfg_rdata), .o_inta(o_inta), .o_intb(o_intb),
    .o_int_id(o_int_id), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
    i_cfg_we    = 1'b1;
    i_cfg_addr  = addr;
    i_cfg_wdata = data;
    tick(1);
    i_cfg_we    = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] addr, input logic [15:0] exp);
    i_cfg_addr = addr;
    #1;
    check(name, o_cfg_rdata, exp);
  endtask

  task automatic check_output(input string name, input logic a, input logic b,
                              input logic [3:0] id, input logic busy);
    check_bit({name, " inta"}, o_inta, a);
    check_bit({name, " intb"}, o_intb, b);
    check({name, " id"}, {12'd0, o_int_id}, {12'd0, id});
    check_bit({name, " busy"}, o_busy, busy);
  endtask

  task automatic pulse_recovery();
    i_recovery = 1'b1;
    tick(1);
    i_recovery = 1'b0;
  endtask

  // Clears mask and pending while the FSM sits in GAP so nothing leftover is granted
  task automatic cleanup();
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd2, 16'h00FF);
    tick(3);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    cfg_write(2'd0, {8'd0, v.mask});
    cfg_write(2'd1, {8'd0, v.route});
    i_irq = v.irq;
    tick(4);
    check_output(tag, v.exp_a, v.exp_b, v.exp_id, v.exp_busy);
    check_reg({tag, " pending"}, 2'd2, {8'd0, v.exp_pend});
    i_irq = '0;
    pulse_recovery();
    check_bit({tag, " lines low"}, o_inta | o_intb, 1'b0);
    cleanup();
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'h00, 8'h28, 1'b1, 1'b0, 4'd3, 1'b1, 8'h20};
    vecs[1] = '{8'hFF, 8'h08, 8'h28, 1'b0, 1'b1, 4'd3, 1'b1, 8'h20};
    vecs[2] = '{8'hF0, 8'h00, 8'h4F, 1'b1, 1'b0, 4'd6, 1'b1, 8'h0F};
    vecs[3] = '{8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 4'd7, 1'b1, 8'h00};
    vecs[4] = '{8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 4'd7, 1'b0, 8'h01};
    vecs[5] = '{8'hFF, 8'hFE, 8'hFF, 1'b1, 1'b0, 4'd0, 1'b1, 8'hFE};
    vecs[6] = '{8'h02, 8'h02, 8'h03, 1'b0, 1'b1, 4'd1, 1'b1, 8'h01};

    rst = 1'b1; i_irq = '0; i_recovery = 1'b0;
    i_cfg_we = 1'b0; i_cfg_addr = 2'd0; i_cfg_wdata = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_output("reset", 1'b0, 1'b0, 4'd0, 1'b0);
    check_reg("reset mask", 2'd0, 16'h0000);
    check_reg("reset status", 2'd3, 16'h0000);

    // Basic latency and completion on line A
    cfg_write(2'd0, 16'h0001);
    cfg_write(2'd1, 16'h0000);
    i_irq[0] = 1'b1;
    tick(3);
    check_reg("lat pending", 2'd2, 16'h0001);
    check_bit("lat early inta", o_inta, 1'b0);
    tick(1);
    check_output("lat grant", 1'b1, 1'b0, 4'd0, 1'b1);
    check_reg("lat status", 2'd3, 16'h8000);
    tick(5);
    pulse_recovery();
    check_output("lat done", 1'b0, 1'b0, 4'd0, 1'b0);
    i_irq = '0;
    tick(4);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);

    // Back-to-back: 3 then 5, with GAP+1 low cycles between
    cfg_write(2'd0, 16'h00FF);
    cfg_write(2'd1, 16'h0008);
    i_irq = 8'h28;
    tick(4);
    check_output("b2b first", 1'b0, 1'b1, 4'd3, 1'b1);
    i_irq = '0;
    pulse_recovery();
    check_output("b2b gap0", 1'b0, 1'b0, 4'd3, 1'b0);
    tick(1);
    check_output("b2b gap1", 1'b0, 1'b0, 4'd3, 1'b0);
    tick(1);
    check_output("b2b gap2", 1'b0, 1'b0, 4'd3, 1'b0);
    tick(1);
    check_output("b2b second", 1'b1, 1'b0, 4'd5, 1'b1);
    pulse_recovery();
    cleanup();

    // Masked source latches, then unmask grants on the next cycle
    i_irq = 8'h04;
    tick(4);
    check_output("masked", 1'b0, 1'b0, 4'd5, 1'b0);
    check_reg("masked pending", 2'd2, 16'h0004);
    cfg_write(2'd0, 16'h0004);
    check_bit("unmask same edge", o_inta, 1'b0);
    tick(1);
    check_output("unmask grant", 1'b1, 1'b0, 4'd2, 1'b1);
    i_irq = '0;
    pulse_recovery();
    cleanup();
    i_irq = 8'h04;
    tick(4);
    cfg_write(2'd2, 16'h0004);
    check_reg("w1c pending", 2'd2, 16'h0000);
    cfg_write(2'd0, 16'h0004);
    tick(2);
    check_output("w1c no req", 1'b0, 1'b0, 4'd2, 1'b0);
    cfg_write(2'd0, 16'h0000);
    i_irq = '0;
    tick(3);

    // Re-edge during service gives a second grant; reset mid-ASSERT
    cfg_write(2'd0, 16'h0002);
    i_irq = 8'h02;
    tick(4);
    check_output("reedge first", 1'b1, 1'b0, 4'd1, 1'b1);
    i_irq = '0;
    tick(3);
    i_irq = 8'h02;
    tick(3);
    check_reg("reedge pending", 2'd2, 16'h0002);
    pulse_recovery();
    check_bit("reedge drop", o_inta, 1'b0);
    tick(3);
    check_output("reedge second", 1'b1, 1'b0, 4'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_output("async reset", 1'b0, 1'b0, 4'd0, 1'b0);
    check_reg("async reset pending", 2'd2, 16'h0000);
    i_irq = '0;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Recovery held high: ignored in IDLE, completes on first ASSERT cycle
    cfg_write(2'd0, 16'h0001);
    i_recovery = 1'b1;
    tick(3);
    check_output("rec idle", 1'b0, 1'b0, 4'd0, 1'b0);
    i_irq = 8'h01;
    tick(4);
    check_output("rec grant", 1'b1, 1'b0, 4'd0, 1'b1);
    tick(1);
    check_output("rec one cycle", 1'b0, 1'b0, 4'd0, 1'b0);
    i_recovery = 1'b0;
    i_irq = '0;
    cleanup();

    // Completion timeout and STATUS bit14
    cfg_write(2'd0, 16'h0010);
    i_irq = 8'h10;
    tick(4);
    check_output("tmo grant", 1'b1, 1'b0, 4'd4, 1'b1);
    check_reg("tmo status busy", 2'd3, 16'h8004);
`ifdef IRQ_TIMEOUT_EN
    tick(TMO - 1);
    check_bit("tmo last cycle", o_inta, 1'b1);
    tick(1);
    check_output("tmo abort", 1'b0, 1'b0, 4'd4, 1'b0);
    check_reg("tmo flag", 2'd3, 16'h4004);
    cfg_write(2'd3, 16'h4000);
    check_reg("tmo flag clear", 2'd3, 16'h0004);
`else
    tick(30);
    check_output("no tmo hold", 1'b1, 1'b0, 4'd4, 1'b1);
    cfg_write(2'd3, 16'h4000);
    check_reg("no tmo status", 2'd3, 16'h8004);
    pulse_recovery();
    check_reg("no tmo done", 2'd3, 16'h0004);
`endif
    i_irq = '0;
    cleanup();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
